nios_adc_ledr_drv: RTL

NIOS_ADC_LEDR_DRV -- requirements
Module: nios_adc_ledr_drv

---
 rtl/nios_adc_ledr_drv_if.sv | 25 ++
 rtl/nios_adc_ledr_drv.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/nios_adc_ledr_drv_if.sv
// nios_adc_ledr_drv_if: Avalon-MM slave register port of the LED driver.
// Master drives the address/strobe/data, slave returns zero-wait readdata.
interface nios_adc_ledr_drv_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios_adc_ledr_drv.sv
// nios_adc_ledr_drv: LED driver with PWM dimming, invert and optional blink.
// Blink logic is built only when NIOS_ADC_LEDR_DRV_BLINK_EN is defined.
module nios_adc_ledr_drv #(
  parameter int PRESCALE = 50
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [9:0]         pattern_in,
  nios_adc_ledr_drv_if.slave bus,
  output logic [9:0]         ledr
);

`ifdef NIOS_ADC_LEDR_DRV_BLINK_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1
  } state_t;
`endif

  state_t      state;
  state_t      state_nx;
  logic [2:0]  ctrl;
  logic [7:0]  duty;
  logic [7:0]  duty_shadow;
  logic [7:0]  duty_nx;
  logic [15:0] presc;
  logic [7:0]  pwm_cnt;
  logic [9:0]  pattern_q;
  logic [9:0]  ledr_nx;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_duty;
  logic        tick;
  logic        wrap;
  logic        pwm_on;
  logic        running;
  logic        phase;

  assign wr      = bus.chipselect & ~bus.write_n;
  assign wr_ctrl = wr && (bus.address == 2'd0);
  assign wr_duty = wr && (bus.address == 2'd1);
  assign duty_nx = wr_duty ? bus.writedata[7:0] : duty;

  assign running = (state != IDLE);
  assign phase   = (state == ON);
  assign tick    = (presc == 16'(PRESCALE - 1));
  assign wrap    = tick && (pwm_cnt == 8'hFF);
  // Full-scale duty must stay lit through count 255 as well
  assign pwm_on  = (duty_shadow == 8'hFF) || (pwm_cnt < duty_shadow);

`ifdef NIOS_ADC_LEDR_DRV_BLINK_EN
  logic [15:0] blink_period;
  logic [15:0] bcnt;
  logic        wr_bp;
  logic        bp_force;
  logic        blinking;
  logic        expiry;
  logic        unused_wdata;

  assign wr_bp        = wr && (bus.address == 2'd2);
  assign bp_force     = wr_bp && ctrl[0];
  assign blinking     = ctrl[1] && (blink_period != 16'd0);
  assign expiry       = blinking && wrap &&
                        (bcnt == blink_period - 16'd1);
  assign unused_wdata = ^bus.writedata[31:16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_period <= 16'd0;
      bcnt         <= 16'd0;
    end else begin
      if (wr_bp)
        blink_period <= bus.writedata[15:0];
      if (!running || !blinking || wr_bp)
        bcnt <= 16'd0;
      else if (wrap)
        bcnt <= expiry ? 16'd0 : bcnt + 16'd1;
    end
  end
`else
  logic unused_wdata;

  assign unused_wdata = ^bus.writedata[31:8];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl <= 3'd0;
      duty <= 8'hFF;
    end else begin
`ifdef NIOS_ADC_LEDR_DRV_BLINK_EN
      if (wr_ctrl)
        ctrl <= bus.writedata[2:0];
`else
      if (wr_ctrl)
        ctrl <= {bus.writedata[2], 1'b0, bus.writedata[0]};
`endif
      if (wr_duty)
        duty <= bus.writedata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc       <= 16'd0;
      pwm_cnt     <= 8'd0;
      duty_shadow <= 8'hFF;
    end else if (!running) begin
      presc   <= 16'd0;
      pwm_cnt <= 8'd0;
    end else begin
      presc <= tick ? 16'd0 : presc + 16'd1;
      if (tick)
        pwm_cnt <= pwm_cnt + 8'd1;
      if (wrap)
        duty_shadow <= duty_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (ctrl[0]) state_nx = ON;
      ON: begin
        if (!ctrl[0])
          state_nx = IDLE;
`ifdef NIOS_ADC_LEDR_DRV_BLINK_EN
        else if (!bp_force && expiry)
          state_nx = OFF;
`endif
      end
`ifdef NIOS_ADC_LEDR_DRV_BLINK_EN
      OFF: begin
        if (!ctrl[0])
          state_nx = IDLE;
        else if (bp_force || !blinking || expiry)
          state_nx = ON;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ledr_nx = {10{ctrl[2]}};
    if (running)
      ledr_nx = (pattern_q & {10{pwm_on && phase}}) ^ {10{ctrl[2]}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= 10'd0;
      ledr      <= 10'd0;
    end else begin
      pattern_q <= pattern_in;
      ledr      <= ledr_nx;
    end
  end

  always_comb begin
    bus.readdata = 32'd0;
    unique case (bus.address)
      2'd0: bus.readdata = {29'd0, ctrl};
      2'd1: bus.readdata = {24'd0, duty};
`ifdef NIOS_ADC_LEDR_DRV_BLINK_EN
      2'd2: bus.readdata = {16'd0, blink_period};
`else
      2'd2: bus.readdata = 32'd0;
`endif
      2'd3: bus.readdata = {14'd0, ledr, 5'd0, state, phase};
      default: bus.readdata = 32'd0;
    endcase
  end

endmodule
